// File: rtl/iram_pkg.sv
// Shared types and constants for the loadable instruction memory.
package iram_pkg;

  // Controller states: zero the array, accept load beats, serve fetches.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } iram_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 128;

  // Value presented on the fetch port whenever fetch is gated.
  localparam int NOP_WORD = 0;

endpackage

// File: rtl/iram_loader_ctrl.sv
// Load controller: clear/load/run FSM, write pointer, pending-load flag,
// beat counter and sticky overflow flag. Drives the array write port.
module iram_loader_ctrl
  import iram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_start,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_ready,
  output logic [CNT_W-1:0]  o_ld_count,
  output logic              o_ld_ovf,
  output logic              o_run,
  output logic              o_we,
  output logic [PTR_W-1:0]  o_waddr,
  output logic [DATA_W-1:0] o_wdata
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  iram_state_e      r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pend, w_pend_nxt;
  logic             r_ovf, w_ovf_nxt;

  // State and control registers; the pending load is dropped on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state, pointer/counter updates and write-port drive.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = r_ovf;
    o_we        = 1'b0;
    o_waddr     = r_ptr;
    o_wdata     = '0;
    o_ld_ready  = 1'b0;
    o_run       = 1'b0;
    case (r_state)
      CLEAR: begin
        o_we = 1'b1;
        if (r_ptr == LAST_PTR) begin
          w_ptr_nxt   = '0;
          w_pend_nxt  = 1'b0;
          w_state_nxt = r_pend ? LOAD : RUN;
        end else begin
          w_ptr_nxt = r_ptr + PTR_W'(1);
        end
      end
      LOAD: begin
        o_ld_ready = 1'b1;
        if (i_ld_valid) begin
          o_we    = 1'b1;
          o_wdata = i_ld_data;
          if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          if (r_ptr == LAST_PTR) begin
            // Array full: pointer holds at the last word.
            w_state_nxt = RUN;
            if (!i_ld_last) begin
              w_ovf_nxt = 1'b1;
            end
          end else begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
            if (i_ld_last) begin
              w_state_nxt = RUN;
            end
          end
        end
      end
      RUN: begin
        o_run = 1'b1;
        if (i_ld_start) begin
          w_pend_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_ptr_nxt   = '0;
          w_state_nxt = CLEAR;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign o_ld_count = r_cnt;
  assign o_ld_ovf   = r_ovf;

endmodule

// File: rtl/iram_loadable.sv
// Run-time loadable instruction memory with a combinational byte-addressed
// fetch port. Fetch returns the NOP word while clearing or loading.
module iram_loadable
  import iram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              MISALIGN,
  output logic              ADDR_ERR,
  output logic              BUSY,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic [CNT_W-1:0]  LD_COUNT,
  output logic              LD_OVF
);

  localparam logic [ADDR_W-1:0] DEPTH_IDX = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_we;
  logic [PTR_W-1:0]  w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_run;
  logic [ADDR_W-1:0] w_index;
  logic              w_in_range;

  iram_loader_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ctrl (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_ld_start (LD_START),
    .i_ld_valid (LD_VALID),
    .i_ld_data  (LD_DATA),
    .i_ld_last  (LD_LAST),
    .o_ld_ready (LD_READY),
    .o_ld_count (LD_COUNT),
    .o_ld_ovf   (LD_OVF),
    .o_run      (w_run),
    .o_we       (w_we),
    .o_waddr    (w_waddr),
    .o_wdata    (w_wdata)
  );

  // Single write port; the array is deliberately not reset, CLEAR zeroes it.
  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Byte address to word index: the low address bit is ignored for data.
  assign w_index    = {1'b0, ADDR[ADDR_W-1:1]};
  assign w_in_range = (w_index < DEPTH_IDX);

  assign MISALIGN = ADDR[0];
  assign ADDR_ERR = ~w_in_range;
  assign BUSY     = ~w_run;
  assign Q        = (w_run && w_in_range) ? r_mem[w_index[PTR_W-1:0]]
                                          : DATA_W'(NOP_WORD);

endmodule

// File: tb/tb_iram_loadable.sv
// Directed bench for iram_loadable: a DEPTH=128 instance (main) and a
// DEPTH=64 instance (out-of-range checks) sharing all inputs.
module tb_iram_loadable;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 128;
  localparam int DEPTH_B = 64;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int CNT_WB  = $clog2(DEPTH_B + 1);

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [ADDR_W-1:0] ADDR = '0;
  logic              LD_START = 1'b0;
  logic              LD_VALID = 1'b0;
  logic [DATA_W-1:0] LD_DATA = '0;
  logic              LD_LAST = 1'b0;

  logic [DATA_W-1:0] q_a, q_b;
  logic              mis_a, mis_b, aerr_a, aerr_b, busy_a, busy_b;
  logic              rdy_a, rdy_b, ovf_a, ovf_b;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_WB-1:0] cnt_b;

  int vectors = 0;
  int errors  = 0;

  iram_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut_a (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .Q(q_a), .MISALIGN(mis_a),
    .ADDR_ERR(aerr_a), .BUSY(busy_a), .LD_START(LD_START), .LD_VALID(LD_VALID),
    .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_READY(rdy_a), .LD_COUNT(cnt_a),
    .LD_OVF(ovf_a)
  );

  iram_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH_B)) dut_b (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .Q(q_b), .MISALIGN(mis_b),
    .ADDR_ERR(aerr_b), .BUSY(busy_b), .LD_START(LD_START), .LD_VALID(LD_VALID),
    .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_READY(rdy_b), .LD_COUNT(cnt_b),
    .LD_OVF(ovf_b)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, input logic v);
    LD_VALID = v;
    LD_DATA  = d;
    LD_LAST  = last;
    step();
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
  endtask

  // Pulse LD_START in RUN, then wait (bounded) for the 128-cycle clear to end.
  task automatic start_load();
    int n;
    LD_START = 1'b1;
    step();
    LD_START = 1'b0;
    n = 0;
    while (rdy_a !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    vectors++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clear_len: got %0d cycles, expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_reset();
    int bad;
    step();
    step();
    vectors++;
    if (busy_a !== 1'b1 || rdy_a !== 1'b0 || cnt_a !== '0 || ovf_a !== 1'b0 || q_a !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rdy=%b cnt=%0d ovf=%b q=%h, expected 1 0 0 0 0000",
               busy_a, rdy_a, cnt_a, ovf_a, q_a);
    end
    RESET = 1'b0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_a !== 1'b1) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL boot_busy: BUSY low in %0d of %0d clear cycles, expected 0", bad, DEPTH);
    end
    vectors++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL boot_run: BUSY=%b on cycle 129, expected 0", busy_a);
    end
    bad = 0;
    for (int a = 0; a < 255; a++) begin
      ADDR = ADDR_W'(a);
      #1;
      if (q_a !== '0 || aerr_a !== 1'b0 || mis_a !== ADDR[0]) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL boot_zero: %0d addresses with Q!=0 or bad flags, expected 0", bad);
    end
  endtask

  task automatic test_load();
    logic [ADDR_W-1:0] addrs [4];
    logic [DATA_W-1:0] exp   [4];
    addrs = '{8'h00, 8'h02, 8'h04, 8'h06};
    exp   = '{16'hF001, 16'h203D, 16'h5080, 16'h0000};
    start_load();
    send_beat(16'hF001, 1'b0, 1'b1);
    send_beat(16'h203D, 1'b0, 1'b1);
    send_beat(16'h5080, 1'b1, 1'b1);
    vectors++;
    if (cnt_a !== CNT_W'(3) || busy_a !== 1'b0 || rdy_a !== 1'b0 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL load_done: cnt=%0d busy=%b rdy=%b ovf=%b, expected 3 0 0 0",
               cnt_a, busy_a, rdy_a, ovf_a);
    end
    for (int i = 0; i < 4; i++) begin
      ADDR = addrs[i];
      #1;
      vectors++;
      if (q_a !== exp[i]) begin
        errors++;
        $display("FAIL load_read[%h]: got %h, expected %h", addrs[i], q_a, exp[i]);
      end
    end
  endtask

  task automatic test_misalign();
    ADDR = 8'h03;
    #1;
    vectors++;
    if (q_a !== 16'h203D || mis_a !== 1'b1 || aerr_a !== 1'b0) begin
      errors++;
      $display("FAIL misalign_03: q=%h mis=%b aerr=%b, expected 203d 1 0", q_a, mis_a, aerr_a);
    end
    ADDR = 8'h80;
    #1;
    vectors++;
    if (q_b !== 16'h0000 || aerr_b !== 1'b1 || mis_b !== 1'b0) begin
      errors++;
      $display("FAIL range_b_80: q=%h aerr=%b mis=%b, expected 0000 1 0", q_b, aerr_b, mis_b);
    end
    vectors++;
    if (q_a !== 16'h0000 || aerr_a !== 1'b0) begin
      errors++;
      $display("FAIL range_a_80: q=%h aerr=%b, expected 0000 0", q_a, aerr_a);
    end
    ADDR = 8'h7E;
    #1;
    vectors++;
    if (aerr_b !== 1'b0) begin
      errors++;
      $display("FAIL range_b_7e: aerr=%b, expected 0", aerr_b);
    end
    ADDR = 8'h02;
    #1;
    vectors++;
    if (q_b !== 16'h203D) begin
      errors++;
      $display("FAIL b_read_02: got %h, expected 203d", q_b);
    end
  endtask

  task automatic test_overflow();
    logic exp_rdy;
    start_load();
    for (int b = 0; b < 130; b++) begin
      exp_rdy = (b < DEPTH);
      vectors++;
      if (rdy_a !== exp_rdy) begin
        errors++;
        $display("FAIL ovf_ready[%0d]: got %b, expected %b", b, rdy_a, exp_rdy);
      end
      send_beat(DATA_W'(32'h1000 + b), 1'b0, 1'b1);
    end
    vectors++;
    if (cnt_a !== CNT_W'(128) || ovf_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ovf_state: cnt=%0d ovf=%b busy=%b, expected 128 1 0", cnt_a, ovf_a, busy_a);
    end
    vectors++;
    if (cnt_b !== CNT_WB'(64) || ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state_b: cnt=%0d ovf=%b, expected 64 1", cnt_b, ovf_b);
    end
    ADDR = 8'hFE;
    #1;
    vectors++;
    if (q_a !== 16'h107F) begin
      errors++;
      $display("FAIL ovf_last_word: got %h, expected 107f", q_a);
    end
    ADDR = 8'hFF;
    #1;
    vectors++;
    if (q_a !== 16'h107F || mis_a !== 1'b1) begin
      errors++;
      $display("FAIL ovf_ff: q=%h mis=%b, expected 107f 1", q_a, mis_a);
    end
    ADDR = 8'h80;
    #1;
    vectors++;
    if (q_a !== 16'h1040) begin
      errors++;
      $display("FAIL ovf_mid_word: got %h, expected 1040", q_a);
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] addrs [4];
    logic [DATA_W-1:0] exp   [4];
    addrs = '{8'h00, 8'h02, 8'h04, 8'h06};
    exp   = '{16'hA1A1, 16'hD4D4, 16'hE5E5, 16'h0000};
    start_load();
    vectors++;
    if (cnt_a !== '0 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_start_clear: cnt=%0d ovf=%b, expected 0 0", cnt_a, ovf_a);
    end
    send_beat(16'hA1A1, 1'b0, 1'b1);
    send_beat(16'hB2B2, 1'b1, 1'b0);
    vectors++;
    if (rdy_a !== 1'b1 || busy_a !== 1'b1 || cnt_a !== CNT_W'(1)) begin
      errors++;
      $display("FAIL bp_idle_beat: rdy=%b busy=%b cnt=%0d, expected 1 1 1", rdy_a, busy_a, cnt_a);
    end
    send_beat(16'hC3C3, 1'b0, 1'b0);
    send_beat(16'hD4D4, 1'b0, 1'b1);
    send_beat(16'hE5E5, 1'b1, 1'b1);
    vectors++;
    if (cnt_a !== CNT_W'(3) || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: cnt=%0d busy=%b, expected 3 0", cnt_a, busy_a);
    end
    for (int i = 0; i < 4; i++) begin
      ADDR = addrs[i];
      #1;
      vectors++;
      if (q_a !== exp[i]) begin
        errors++;
        $display("FAIL bp_read[%h]: got %h, expected %h", addrs[i], q_a, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midload();
    int bad;
    start_load();
    for (int i = 0; i < 5; i++) begin
      send_beat(DATA_W'(32'hAAA0 + i), 1'b0, 1'b1);
    end
    vectors++;
    if (cnt_a !== CNT_W'(5) || busy_a !== 1'b1 || rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_load: cnt=%0d busy=%b rdy=%b, expected 5 1 1", cnt_a, busy_a, rdy_a);
    end
    #2;
    RESET = 1'b1;
    #1;
    vectors++;
    if (busy_a !== 1'b1 || rdy_a !== 1'b0 || cnt_a !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b rdy=%b cnt=%0d, expected 1 0 0", busy_a, rdy_a, cnt_a);
    end
    step();
    step();
    RESET = 1'b0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_a !== 1'b1 || rdy_a !== 1'b0) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reclear_busy: %0d bad cycles, expected 0", bad);
    end
    vectors++;
    if (busy_a !== 1'b0 || cnt_a !== '0 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL reclear_run: busy=%b cnt=%0d ovf=%b, expected 0 0 0", busy_a, cnt_a, ovf_a);
    end
    bad = 0;
    for (int a = 0; a < 255; a++) begin
      ADDR = ADDR_W'(a);
      #1;
      if (q_a !== '0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reclear_zero: %0d nonzero addresses, expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_misalign();
    test_overflow();
    test_backpressure();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/iram_loadable.md
# iram_loadable

Parameterised, run-time loadable instruction memory for the single-cycle core. It replaces a fixed program baked in at reset with a zero-on-boot array that is filled over a valid/ready load channel. The core keeps a combinational, byte-addressed fetch port. Fetch is gated while the block is clearing or loading, and the block flags misaligned and out-of-range fetches.

## Interface
Parameters:
- DATA_W, 16, instruction word width.
- ADDR_W, 8, byte-address width of the fetch port.
- DEPTH, 128, number of words; must be ≤ 2^(ADDR_W-1).

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- ADDR  in  ADDR_W  fetch byte address; word index = ADDR[ADDR_W-1:1].
- Q  out  DATA_W  fetched instruction word.
- MISALIGN  out  1  ADDR[0] set.
- ADDR_ERR  out  1  word index ≥ DEPTH.
- BUSY  out  1  block not in RUN; the core must stall fetch.
- LD_START  in  1  single-cycle request to clear and reload.
- LD_VALID  in  1  load beat valid.
- LD_DATA  in  DATA_W  load word.
- LD_LAST  in  1  final beat of the program.
- LD_READY  out  1  block accepts a beat this cycle.
- LD_COUNT  out  $clog2(DEPTH+1)  words accepted in the last or current load.
- LD_OVF  out  1  sticky: load hit DEPTH words without LD_LAST.

## Operation
- FSM has three states:
  - CLEAR: writes 0 to mem[ptr], ptr++; after the write at ptr=DEPTH-1, ptr←0 and the FSM goes to LOAD if a load is pending, else RUN.
  - LOAD: LD_READY=1. Each LD_VALID&LD_READY beat writes LD_DATA to mem[ptr], then ptr++ and LD_COUNT++. The FSM goes to RUN on a beat with LD_LAST, or on the beat at ptr=DEPTH-1. In the second case LD_OVF←1 if LD_LAST=0.
  - RUN: fetch is live. LD_START sets pending, clears LD_COUNT and LD_OVF, and moves to CLEAR.
- LD_START in CLEAR or LOAD is ignored. After reset the FSM enters CLEAR with pending=0, so the memory boots all-zero.
- Fetch is combinational:
  - Q = mem[index] when the state is RUN and index < DEPTH; otherwise Q = 0.
  - MISALIGN and ADDR_ERR are combinational from ADDR in every state.
  - A misaligned fetch still returns mem[index], i.e. the low bit is ignored.
- Memory has a single write port, with at most one write per cycle. The array itself has no reset.
- Arithmetic: ptr and LD_COUNT are unsigned, never wrap, and saturate at DEPTH-1 and DEPTH respectively. LD_COUNT holds its value through RUN.

## Timing
- Reset values (asserted asynchronously): state=CLEAR, ptr=0, pending=0, BUSY=1, LD_READY=0, LD_COUNT=0, LD_OVF=0, Q=0.
- CLEAR lasts exactly DEPTH cycles. With pending=0, BUSY falls on the edge after the last clear write.
- Beat accepted at edge k → word readable on Q in the cycle after edge k, once in RUN. The RUN transition occurs on the same edge as the final beat, so BUSY=0 the following cycle.
- LD_READY depends only on state, never on LD_VALID. LD_DATA and LD_LAST are sampled only on an accepted beat, and LD_VALID may drop between beats.
- Reset mid-operation: LOAD and CLEAR are aborted immediately and the pending load is discarded. Memory is re-zeroed by the following CLEAR.

## Structure
- Shared package iram_pkg holds:
  - state enum {CLEAR, LOAD, RUN};
  - default width constants;
  - NOP_WORD = 0, the gated fetch value.
- One sub-module, iram_loader_ctrl, contains the FSM, ptr, pending, LD_COUNT and LD_OVF. It drives the write enable, write address and write data.
- The top level holds the array and the combinational fetch and flag logic.

## Test plan
- Reset, then run 128 cycles → BUSY=1 throughout and 0 on cycle 129. Q=0 for ADDR 0x00–0xFE, ADDR_ERR=0.
- LD_START; after 128 clear cycles, drive beats 0xF001, 0x203D, 0x5080, with LD_LAST on the third beat → LD_COUNT=3, BUSY=0. Expected reads:
  - ADDR 0x00 → Q=0xF001
  - ADDR 0x02 → Q=0x203D
  - ADDR 0x04 → Q=0x5080
  - ADDR 0x06 → Q=0
- Backpressure: LD_VALID toggled 1,0,0,1,1 → exactly three words written, in order, LD_COUNT=3.
- Overflow: 130 beats, none with LD_LAST → 128 words accepted, LD_OVF=1. LD_READY=0 from the 129th beat onward, and mem[127] holds beat 128.
- ADDR=0x03 in RUN → Q=mem[1], MISALIGN=1. With DEPTH=64, ADDR=0x80 → Q=0, ADDR_ERR=1.
- Assert RESET after 5 beats of a load → BUSY stays 1, then CLEAR runs. Afterwards all addresses read 0, LD_COUNT=0, and the core sees BUSY=0 after 128 cycles.
